circuit_encoder8: RTL and testbench

//   8-input one-hot to 3-bit binary encoder with registered outputs.

---
 rtl/circuit_encoder8.sv | 74 +++++++
 tb/tb_circuit_encoder8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/circuit_encoder8.sv
// One-hot to 3-bit binary encoder with registered index, valid and multi-hot flags.
// Multi-hot inputs resolve by fixed priority selected at elaboration time.
module circuit_encoder8 #(
   parameter int unsigned PRIORITY_HIGH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic x1,
   input  logic x2,
   input  logic x3,
   input  logic x4,
   input  logic x5,
   input  logic x6,
   input  logic x7,
   input  logic x8,
   output logic y1,
   output logic y2,
   output logic y3,
   output logic valid,
   output logic multi
);

   logic [7:0] w_sel;
   logic [2:0] w_idx;
   logic       w_valid;
   logic       w_multi;

   logic [2:0] r_idx;
   logic       r_valid;
   logic       r_multi;

   assign w_sel   = {x8, x7, x6, x5, x4, x3, x2, x1};
   assign w_valid = |w_sel;
   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign w_multi = |(w_sel & (w_sel - 8'd1));

   // The last match in scan order wins, so scan direction sets the priority.
   generate
      if (PRIORITY_HIGH != 0) begin : g_prio_high
         always_comb begin
            w_idx = 3'd0;
            for (int i = 0; i < 8; i++) begin
               if (w_sel[i]) w_idx = 3'(i);
            end
         end
      end else begin : g_prio_low
         always_comb begin
            w_idx = 3'd0;
            for (int i = 7; i >= 0; i--) begin
               if (w_sel[i]) w_idx = 3'(i);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= 3'd0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
      end else begin
         r_idx   <= w_idx;
         r_valid <= w_valid;
         r_multi <= w_multi;
      end
   end

   assign y1    = r_idx[0];
   assign y2    = r_idx[1];
   assign y3    = r_idx[2];
   assign valid = r_valid;
   assign multi = r_multi;

endmodule

// File: tb/tb_circuit_encoder8.sv
// Directed bench for circuit_encoder8: both priority settings driven from the same inputs.
// Observed vectors are packed as {y3,y2,y1,valid,multi}.
module tb_circuit_encoder8;

   logic       clk;
   logic       rst_n;
   logic [7:0] x;

   logic y1_hi, y2_hi, y3_hi, valid_hi, multi_hi;
   logic y1_lo, y2_lo, y3_lo, valid_lo, multi_lo;

   logic [4:0] obs_hi;
   logic [4:0] obs_lo;

   int n_pass;
   int n_total;

   assign obs_hi = {y3_hi, y2_hi, y1_hi, valid_hi, multi_hi};
   assign obs_lo = {y3_lo, y2_lo, y1_lo, valid_lo, multi_lo};

   circuit_encoder8 #(.PRIORITY_HIGH(1)) u_dut_hi (
      .clk   (clk),
      .rst_n (rst_n),
      .x1    (x[0]),
      .x2    (x[1]),
      .x3    (x[2]),
      .x4    (x[3]),
      .x5    (x[4]),
      .x6    (x[5]),
      .x7    (x[6]),
      .x8    (x[7]),
      .y1    (y1_hi),
      .y2    (y2_hi),
      .y3    (y3_hi),
      .valid (valid_hi),
      .multi (multi_hi)
   );

   circuit_encoder8 #(.PRIORITY_HIGH(0)) u_dut_lo (
      .clk   (clk),
      .rst_n (rst_n),
      .x1    (x[0]),
      .x2    (x[1]),
      .x3    (x[2]),
      .x4    (x[3]),
      .x5    (x[4]),
      .x6    (x[5]),
      .x7    (x[6]),
      .x8    (x[7]),
      .y1    (y1_lo),
      .y2    (y2_lo),
      .y3    (y3_lo),
      .valid (valid_lo),
      .multi (multi_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      x       = 8'hFF;

      // reset holds outputs low before any clock edge
      #2;
      check("reset_hi", obs_hi, 5'b000_0_0);
      check("reset_lo", obs_lo, 5'b000_0_0);

      @(negedge clk);
      rst_n = 1'b1;

      // one-hot sweep
      for (int i = 0; i < 8; i++) begin
         logic [7:0] one;
         logic [4:0] exp_v;
         one   = 8'd1;
         x     = one << i;
         exp_v = {3'(i), 1'b1, 1'b0};
         @(posedge clk);
         #1;
         check($sformatf("onehot_hi_x%0d", i + 1), obs_hi, exp_v);
         check($sformatf("onehot_lo_x%0d", i + 1), obs_lo, exp_v);
         if (obs_hi === exp_v && obs_lo === exp_v)
            $display("Test for x%0d = 1 was successful!", i + 1);
         @(negedge clk);
      end

      // zero input
      x = 8'h00;
      @(posedge clk);
      #1;
      check("zero_hi", obs_hi, 5'b000_0_0);
      check("zero_lo", obs_lo, 5'b000_0_0);

      // multi-hot 1000_0101
      @(negedge clk);
      x = 8'b1000_0101;
      @(posedge clk);
      #1;
      check("multi_hi", obs_hi, 5'b111_1_1);
      check("multi_lo", obs_lo, 5'b000_1_1);

      // another multi-hot pattern 0011_0010
      @(negedge clk);
      x = 8'b0011_0010;
      @(posedge clk);
      #1;
      check("multi2_hi", obs_hi, 5'b101_1_1);
      check("multi2_lo", obs_lo, 5'b001_1_1);

      // latency: change between edges, output waits for the edge
      @(negedge clk);
      x = 8'h04;
      @(posedge clk);
      #1;
      check("lat_first", obs_hi, 5'b010_1_0);
      @(negedge clk);
      x = 8'h40;
      #1;
      check("lat_hold", obs_hi, 5'b010_1_0);
      @(posedge clk);
      #1;
      check("lat_update", obs_hi, 5'b110_1_0);

      // async reset mid-run
      @(negedge clk);
      x = 8'h80;
      @(posedge clk);
      #1;
      check("pre_rst_hi", obs_hi, 5'b111_1_0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_hi", obs_hi, 5'b000_0_0);
      check("async_rst_lo", obs_lo, 5'b000_0_0);
      x = 8'h24;
      #1;
      rst_n = 1'b1;
      #1;
      check("post_release_hi", obs_hi, 5'b000_0_0);
      @(posedge clk);
      #1;
      check("reencode_hi", obs_hi, 5'b101_1_1);
      check("reencode_lo", obs_lo, 5'b010_1_1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
